// File: rtl/uart_txrx_core.sv
// Full-duplex 8N1 UART: independent transmit and receive paths sharing one clock.
// TX drives the line from its registered state; RX samples mid-bit after a 2-flop synchronizer.
module uart_txrx_core #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_bit_end;

  state_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic          rx_meta_q, rx_sync_q;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    unique case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (i_TX_DV) begin
          tx_byte_d  = i_TX_Byte;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_idx_d   = '0;
            tx_state_d = S_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = S_CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_CLEANUP: tx_state_d = S_IDLE;
      default:   tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // Line level is a pure function of registered state, so each bit lasts exactly one bit period.
  always_comb begin
    o_TX_Serial = 1'b1;
    unique case (tx_state_q)
      S_START: o_TX_Serial = 1'b0;
      S_DATA:  o_TX_Serial = tx_byte_q[tx_idx_q];
      default: o_TX_Serial = 1'b1;
    endcase
  end

  assign o_TX_Done   = (tx_state_q == S_STOP) && tx_bit_end;
  assign o_TX_Active = ((tx_state_q == S_START) || (tx_state_q == S_DATA) ||
                        (tx_state_q == S_STOP)) && !o_TX_Done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (!rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == BIT_MID) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_sync_q;
          if (rx_idx_q == 3'd7) begin
            rx_idx_d   = '0;
            rx_state_d = S_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // A low stop bit is a framing error: the assembled byte is dropped.
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_CLEANUP;
          if (rx_sync_q) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_CLEANUP: rx_state_d = S_IDLE;
      default:   rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_meta_q  <= i_RX_Serial;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  assign o_RX_DV   = rx_dv_q;
  assign o_RX_Byte = rx_byte_q;

endmodule

// File: tb/tb_uart_txrx_core.sv
// Scoreboard bench for uart_txrx_core: loopback and directly driven RX frames,
// expected bytes queued at stimulus time and compared on every o_RX_DV pulse.
module tb_uart_txrx_core;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       loop_en = 1'b1;
  logic       rx_drive = 1'b1;
  logic       rx_line;

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int exp_dv = 0;
  logic [7:0] exp_q[$];

  assign rx_line = loop_en ? tx_serial : rx_drive;

  uart_txrx_core #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .o_TX_Active(tx_active),
    .o_TX_Serial(tx_serial),
    .o_TX_Done  (tx_done),
    .i_RX_Serial(rx_line),
    .o_RX_DV    (rx_dv),
    .o_RX_Byte  (rx_byte)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every received byte is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_dv === 1'b1) begin
      dv_cnt++;
      if (exp_q.size() == 0) checkOutput("rx_dv_unexpected", 32'(exp_q.size()), 32'd1);
      else checkOutput("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
    end
  end

  task automatic sendAndWait(input logic [7:0] b, input int poke_at, output int act, output int dn);
    logic seen;
    exp_q.push_back(b);
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv = 1'b0;
    act = 0;
    dn = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 * CPB && !seen; i++) begin
      if (i == poke_at) begin
        tx_dv = 1'b1;
        tx_byte = 8'h99;
      end else begin
        tx_dv = 1'b0;
      end
      if (tx_active === 1'b1) act++;
      if (tx_done === 1'b1) begin
        dn++;
        seen = 1'b1;
      end
      @(negedge clk);
    end
    tx_dv = 1'b0;
    if (!seen) checkOutput("tx_done_timeout", 32'(seen), 32'd1);
    repeat (3) begin
      if (tx_done === 1'b1) dn++;
      @(negedge clk);
    end
  endtask

  task automatic waitRx(input int target);
    for (int i = 0; i < 4 * CPB && dv_cnt < target; i++) @(negedge clk);
    checkOutput("rx_dv_count", 32'(dv_cnt), 32'(target));
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drive = frame[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drive = 1'b1;
  endtask

  initial begin
    int act;
    int dn;
    int errs;
    logic [9:0] frame;
    logic [7:0] seq [3];

    repeat (3) @(negedge clk);
    checkOutput("rst_tx_serial", 32'(tx_serial), 32'd1);
    checkOutput("rst_tx_active", 32'(tx_active), 32'd0);
    checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
    checkOutput("rst_rx_dv", 32'(rx_dv), 32'd0);
    checkOutput("rst_rx_byte", 32'(rx_byte), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] loopback 0x3F");
    sendAndWait(8'h3F, -1, act, dn);
    checkOutput("tx_active_len_in_range", 32'((act >= 10 * CPB - 1) && (act <= 10 * CPB + 1)), 32'd1);
    checkOutput("tx_done_pulses", 32'(dn), 32'd1);
    exp_dv++;
    waitRx(exp_dv);

    $display("[TB] back-to-back 0x00 0xFF 0xA5");
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    seq[2] = 8'hA5;
    for (int j = 0; j < 3; j++) begin
      sendAndWait(seq[j], -1, act, dn);
      checkOutput("b2b_done_pulses", 32'(dn), 32'd1);
      exp_dv++;
      waitRx(exp_dv);
    end

    $display("[TB] bit timing 0x37");
    exp_q.push_back(8'h37);
    frame = {1'b1, 8'h37, 1'b0};
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = 8'h37;
    @(negedge clk);
    tx_dv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      errs = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_serial !== frame[k]) errs++;
        @(negedge clk);
      end
      checkOutput($sformatf("tx_bit%0d_errs", k), 32'(errs), 32'd0);
    end
    checkOutput("tx_line_after_frame", 32'(tx_serial), 32'd1);
    exp_dv++;
    waitRx(exp_dv);
    repeat (5) @(negedge clk);

    $display("[TB] rx glitch then 0x5A");
    loop_en = 1'b0;
    rx_drive = 1'b0;
    repeat (50) @(negedge clk);
    rx_drive = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch_no_dv", 32'(dv_cnt), 32'(exp_dv));
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1);
    exp_dv++;
    waitRx(exp_dv);

    $display("[TB] framing error 0x12");
    applyStimulus(8'h12, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("frame_err_no_dv", 32'(dv_cnt), 32'(exp_dv));
    checkOutput("frame_err_byte_held", 32'(rx_byte), 32'h5A);

    $display("[TB] tx_dv during active frame");
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    sendAndWait(8'h44, 500, act, dn);
    checkOutput("ignore_done_pulses", 32'(dn), 32'd1);
    exp_dv++;
    waitRx(exp_dv);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("ignore_tx_idle", 32'(tx_active), 32'd0);
    checkOutput("ignore_no_extra_dv", 32'(dv_cnt), 32'(exp_dv));

    $display("[TB] reset mid-frame");
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = 8'hC3;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tx_serial", 32'(tx_serial), 32'd1);
    checkOutput("midrst_tx_active", 32'(tx_active), 32'd0);
    checkOutput("midrst_rx_dv", 32'(rx_dv), 32'd0);
    checkOutput("midrst_rx_byte", 32'(rx_byte), 32'd0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("midrst_no_dv", 32'(dv_cnt), 32'(exp_dv));
    sendAndWait(8'h6E, -1, act, dn);
    exp_dv++;
    waitRx(exp_dv);

    repeat (10) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
